v_rst_seq: RTL and testbench
============================

// Module: v_rst_seq
// PURPOSE
//  Reset generator and sequencer for v_dff_async-based logic. It takes the raw
//  board reset and a software reset request and produces NUM_OUT per-stage
//  active-low resets. Each output asserts asynchronously and deasserts
//  synchronously, in a fixed stagger: out[0] first, out[NUM_OUT-1] last.
//  It also drives an active-high clr_out for direct use on primitive clr pins.
// PARAMETERS
//  SYNC_STAGES  2   depth of the rst_n synchronizer chain (>=2)
//  NUM_OUT      4   number of sequenced reset outputs (>=1)
//  HOLD_CYCLES  16  cycles all outputs stay asserted after sync reset release (>=1)
//  GAP_CYCLES   4   cycles between consecutive output releases (>=1)
// PORTS
//  clk        in   1        single clock; all state is on posedge clk
//  rst_n      in   1        async active-low reset; may change at any time
//  soft_req   in   1        sync pulse, active-high: request a full re-sequence
//  rst_out_n  out  NUM_OUT  per-stage resets, active-low
//  clr_out    out  1        active-high; equals ~rst_out_n[0]
//  busy       out  1        1 while any rst_out_n bit is 0
//  done       out  1        1-cycle pulse when the last output releases
// BEHAVIOUR
//  - rst_n=0, async: sync chain=0, FSM=RST, counter=0, rst_out_n=0,
//    clr_out=1, busy=1, done=0. These take effect immediately, with no clock edge.
//  - Synchronizer: SYNC_STAGES flops, async-cleared by rst_n, D of the first
//    flop tied to 1. Edges are counted from the first posedge after rst_n rises
//    (edge 1). sync_n=1 after edge SYNC_STAGES.
//  - FSM states:
//    - RST: leave only when sync_n=1; go to HOLD with cnt=0.
//    - HOLD: cnt increments each cycle. When cnt==HOLD_CYCLES-1, go to REL with
//      idx=0 and release rst_out_n[0] on the same edge.
//    - REL: cnt counts GAP_CYCLES. On each wrap, release bit idx+1 and increment
//      idx. The edge that releases bit NUM_OUT-1 enters DONE and pulses done.
//    - DONE: idle; rst_out_n all 1, busy=0.
//  - Release timing with defaults: out[i] releases at edge
//    SYNC_STAGES+HOLD_CYCLES+i*GAP_CYCLES.
//  - done=1 on the cycle that follows the edge releasing out[NUM_OUT-1].
//  - Once released, an output stays 1 until re-asserted. Outputs never glitch;
//    each is driven directly by a flop.
//  - soft_req=1 sampled in any state except RST:
//    - next edge: rst_out_n=0, go to HOLD, cnt=0, idx=0.
//    - This restarts the sequence, including mid-HOLD and mid-REL.
//  - soft_req in RST is ignored.
//  - rst_n dropping mid-sequence overrides everything and returns the block to
//    the reset state asynchronously.
//  - Simultaneous events: soft_req on the edge that would release a bit wins;
//    that bit stays 0.
//  - Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES))+1. The counter
//    saturates in DONE; it never wraps into a spurious release.
//  - NUM_OUT=1: DONE is entered on the out[0] release edge.
// TESTING (defaults unless stated)
//  - Power-on: rst_n 0->1 between edges. Required:
//    - rst_out_n = 0000 through edge 17.
//    - bit0 releases at 18, bit1 at 22, bit2 at 26, bit3 at 30.
//    - done pulses for one cycle after edge 30; busy falls after edge 30.
//  - Async assert: drive rst_n=0 mid-clock while in DONE. Required: rst_out_n=0
//    and clr_out=1 within the same delta, with no clock edge.
//  - Soft reset from DONE: one-cycle soft_req at edge N. Required:
//    rst_out_n=0000 after edge N; bit0 releases at edge N+16; done after N+28.
//  - Soft reset mid-REL: soft_req on the edge that would release bit2.
//    Required: bit2 stays 0, all bits return to 0, and the sequence restarts
//    (bit0 releases 16 edges later).
//  - Glitchy rst_n: pulse rst_n low for less than 1 cycle during REL.
//    Required: full reset, then a full restart with the power-on timing.
//  - Param sweep SYNC_STAGES=3, NUM_OUT=1, HOLD=1, GAP=1. Required: out[0]
//    releases at edge 4 and done pulses after edge 4.

Source files
------------

// File: rtl/v_rst_seq.sv
// rtl/v_rst_seq.sv - staggered reset sequencer: async assert, sync release, soft re-sequence
// Outputs and clr_out come straight from flops so downstream reset pins never see decode glitches.
module v_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               clr_out,
    output logic               busy,
    output logic               done
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        ST_RST,
        ST_HOLD,
        ST_REL,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 clr_q;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_RST;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            clr_q   <= ~out_d[0];
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            // Looking one stage early lets HOLD start on the edge the chain output goes high.
            ST_RST: begin
                if (sync_q[SYNC_STAGES-2]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    out_d[0] = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    if (NUM_OUT == 1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REL;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REL: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    idx_d    = idx_q + IW'(1);
                    out_d[0] = 1'b1;
                    for (int i = 1; i < NUM_OUT; i++) begin
                        out_d[i] = out_q[i-1];
                    end
                    if (32'(idx_q) == NUM_OUT - 2) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
            end
        endcase
        // Soft request overrides any release scheduled on the same edge.
        if (soft_req && (state_q != ST_RST)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign rst_out_n = out_q;
    assign clr_out   = clr_q;
    assign busy      = ~(&out_q);
    assign done      = done_q;
endmodule

// File: tb/tb_v_rst_seq.sv
// tb/tb_v_rst_seq.sv - scoreboard bench for v_rst_seq: release edges, soft restarts, async reset
module tb_v_rst_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_req = 1'b0;
    logic [3:0] rst_out_n;
    logic       clr_out, busy, done;
    logic [0:0] rst_out2_n;
    logic       clr2, busy2, done2;

    always #5 clk = ~clk;

    v_rst_seq dut (
        .clk(clk), .rst_n(rst_n), .soft_req(soft_req),
        .rst_out_n(rst_out_n), .clr_out(clr_out), .busy(busy), .done(done)
    );

    v_rst_seq #(.SYNC_STAGES(3), .NUM_OUT(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .soft_req(1'b0),
        .rst_out_n(rst_out2_n), .clr_out(clr2), .busy(busy2), .done(done2)
    );

    typedef struct {
        int         e;
        logic [3:0] o;
        logic       b;
        logic       d;
    } exp_t;

    exp_t       expq[$];
    int         vecs = 0;
    int         errs = 0;
    int         ecnt = 0;
    logic       mon_en = 1'b0;
    logic [6:0] prev = '0;
    logic [6:0] cur;
    exp_t       x;

    always @(posedge clk) ecnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h required %0h (t=%0t edge=%0d)", name, act, req, $time, ecnt);
        end
    endtask

    // Every change of the observed outputs must match the next scheduled expectation.
    always @(negedge clk) begin
        cur = {rst_out_n, clr_out, busy, done};
        if (mon_en && (cur !== prev)) begin
            if (expq.size() == 0) begin
                chk("unexpected_change", 32'(cur), 32'(prev));
            end else begin
                x = expq.pop_front();
                chk("change_edge", ecnt, x.e);
                chk("change_value", 32'(cur), 32'({x.o, ~x.o[0], x.b, x.d}));
            end
        end
        prev = cur;
    end

    task automatic push(input int e, input logic [3:0] o, input logic b, input logic d);
        exp_t t;
        t.e = e; t.o = o; t.b = b; t.d = d;
        expq.push_back(t);
    endtask

    // Full sequence whose HOLD phase starts on edge s.
    task automatic push_seq(input int s);
        push(s + 16, 4'b0001, 1'b1, 1'b0);
        push(s + 20, 4'b0011, 1'b1, 1'b0);
        push(s + 24, 4'b0111, 1'b1, 1'b0);
        push(s + 28, 4'b1111, 1'b0, 1'b1);
        push(s + 29, 4'b1111, 1'b0, 1'b0);
    endtask

    task automatic wait_edge(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic soft_at(input int n);
        wait_edge(n - 1);
        soft_req = 1'b1;
        wait_edge(n);
        soft_req = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out"}, 32'(rst_out_n), 32'h0);
        chk({tag, "_clr"}, 32'(clr_out), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        #23;
        chk_reset_state("reset");
        chk("reset_out2", 32'(rst_out2_n), 32'h0);
        chk("reset_clr2", 32'(clr2), 32'h1);
        #4;
        rst_n  = 1'b1;
        ecnt   = 0;
        mon_en = 1'b1;
        push_seq(2);
        for (int e = 1; e <= 8; e++) begin
            wait_edge(e);
            chk("p2_out", 32'(rst_out2_n), (e >= 4) ? 32'h1 : 32'h0);
            chk("p2_done", 32'(done2), (e == 4) ? 32'h1 : 32'h0);
        end
        wait_edge(35);
        chk("poweron_drained", expq.size(), 0);

        push(40, 4'b0000, 1'b1, 1'b0);
        push_seq(40);
        soft_at(40);
        wait_edge(75);
        chk("soft_done_drained", expq.size(), 0);

        push(80, 4'b0000, 1'b1, 1'b0);
        push(96, 4'b0001, 1'b1, 1'b0);
        push(100, 4'b0011, 1'b1, 1'b0);
        push(104, 4'b0000, 1'b1, 1'b0);
        push_seq(104);
        soft_at(80);
        soft_at(104);
        wait_edge(140);
        chk("soft_rel_drained", expq.size(), 0);

        push(150, 4'b0000, 1'b1, 1'b0);
        push(166, 4'b0001, 1'b1, 1'b0);
        soft_at(150);
        wait_edge(168);
        chk("pre_glitch_drained", expq.size(), 0);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("glitch");
        #1 rst_n = 1'b1;
        ecnt = 0;
        #3 mon_en = 1'b1;
        push_seq(2);
        wait_edge(35);
        chk("glitch_drained", expq.size(), 0);

        wait_edge(40);
        mon_en = 1'b0;
        chk("done_state_out", 32'(rst_out_n), 32'hf);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("async");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
